// File: rtl/matmul_pkg.sv
// Shared definitions for the sequential NxN matrix multiplier.
package matmul_pkg;

    // Two-state controller encoding
    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_COMPUTE = 1'b1;

    // Result element width: full product plus enough headroom for an N-term sum
    function automatic int unsigned cw_f(input int unsigned dw, input int unsigned n);
        return 2 * dw + $clog2(n);
    endfunction

    // Width of the i/j/k loop counters; never narrower than one bit
    function automatic int unsigned idx_w_f(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // LSB position of row-major element (r,c) in a packed N*N*W vector
    function automatic int unsigned elem_lsb(input int unsigned r, input int unsigned c,
                                             input int unsigned n, input int unsigned w);
        return (r * n + c) * w;
    endfunction

endpackage

// File: rtl/matmul_seq_nxn_mac.sv
// Single multiply-accumulate step; purely combinational, the caller owns the register.
module mac_unit #(
    parameter int unsigned DW     = 8,
    parameter int unsigned CW     = 18,
    parameter int unsigned SIGNED = 0
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [CW-1:0] acc_in,
    input  logic          clr,
    output logic [CW-1:0] acc_next
);

    logic [CW-1:0] prod_ext;

    generate
        if (SIGNED != 0) begin : g_signed
            logic signed [2*DW-1:0] prod;
            // Operands widened first so the product keeps its sign at full width
            always_comb prod = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
            // Sign-extend the product to the accumulator width
            always_comb prod_ext = {{(CW-2*DW){prod[2*DW-1]}}, prod};
        end else begin : g_unsigned
            logic [2*DW-1:0] prod;
            // Zero-extended operands give an exact unsigned product
            always_comb prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
            // Zero-extend the product to the accumulator width
            always_comb prod_ext = {{(CW-2*DW){1'b0}}, prod};
        end
    endgenerate

    // Accumulate, or restart the sum when clr is set
    always_comb acc_next = (clr ? '0 : acc_in) + prod_ext;

endmodule

// File: rtl/matmul_seq_nxn.sv
// Sequential NxN integer matrix multiplier, C = A x B, one MAC per clock.
module matmul_seq_nxn
    import matmul_pkg::*;
#(
    parameter int unsigned N      = 3,
    parameter int unsigned DW     = 8,
    parameter int unsigned SIGNED = 0,
    parameter int unsigned CW     = cw_f(DW, N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N*N*DW-1:0] A_flat,
    input  logic [N*N*DW-1:0] B_flat,
    output logic [N*N*CW-1:0] C_flat,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IW = idx_w_f(N);
    localparam int unsigned AW = N * N * DW;
    localparam int unsigned RW = N * N * CW;

    logic          state_q, state_d;
    logic [AW-1:0] opa_q, opa_d;
    logic [AW-1:0] opb_q, opb_d;
    logic [IW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [CW-1:0] acc_q, acc_d;
    logic [RW-1:0] buf_q, buf_d;
    logic [RW-1:0] c_q, c_d;
    logic          done_q, done_d;

    logic          load, mac_en;
    logic          last_k, last_j, last_i, last_mac;
    logic [DW-1:0] a_elem, b_elem;
    logic [CW-1:0] acc_next;

    // Loop-end flags; k runs fastest, then j, then i
    always_comb begin
        last_k   = (k_q == IW'(N - 1));
        last_j   = (j_q == IW'(N - 1));
        last_i   = (i_q == IW'(N - 1));
        last_mac = last_k && last_j && last_i;
    end

    // Select A[i][k] and B[k][j] from the latched operands
    always_comb begin
        a_elem = opa_q[elem_lsb(32'(i_q), 32'(k_q), N, DW) +: DW];
        b_elem = opb_q[elem_lsb(32'(k_q), 32'(j_q), N, DW) +: DW];
    end

    mac_unit #(
        .DW     (DW),
        .CW     (CW),
        .SIGNED (SIGNED)
    ) u_mac (
        .a        (a_elem),
        .b        (b_elem),
        .acc_in   (acc_q),
        .clr      (k_q == '0),
        .acc_next (acc_next)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: start is only honoured while idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start)    state_d = ST_COMPUTE;
            ST_COMPUTE: if (last_mac) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and datapath strobes
    always_comb begin
        busy   = (state_q == ST_COMPUTE);
        load   = (state_q == ST_IDLE) && start;
        mac_en = (state_q == ST_COMPUTE);
    end

    // Datapath next state: operand latch, loop counters, accumulator, result buffer
    always_comb begin
        opa_d  = opa_q;
        opb_d  = opb_q;
        i_d    = i_q;
        j_d    = j_q;
        k_d    = k_q;
        acc_d  = acc_q;
        buf_d  = buf_q;
        c_d    = c_q;
        done_d = 1'b0;
        if (load) begin
            opa_d = A_flat;
            opb_d = B_flat;
            i_d   = '0;
            j_d   = '0;
            k_d   = '0;
            acc_d = '0;
        end else if (mac_en) begin
            if (last_k) begin
                buf_d[elem_lsb(32'(i_q), 32'(j_q), N, CW) +: CW] = acc_next;
                acc_d = '0;
                k_d   = '0;
                if (last_j) begin
                    j_d = '0;
                    i_d = last_i ? '0 : i_q + IW'(1);
                end else begin
                    j_d = j_q + IW'(1);
                end
            end else begin
                acc_d = acc_next;
                k_d   = k_q + IW'(1);
            end
            // Publish the whole matrix at once so C_flat is never seen half-updated
            if (last_mac) begin
                c_d    = buf_d;
                done_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_q  <= '0;
            opb_q  <= '0;
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            acc_q  <= '0;
            buf_q  <= '0;
            c_q    <= '0;
            done_q <= 1'b0;
        end else begin
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            i_q    <= i_d;
            j_q    <= j_d;
            k_q    <= k_d;
            acc_q  <= acc_d;
            buf_q  <= buf_d;
            c_q    <= c_d;
            done_q <= done_d;
        end
    end

    assign C_flat = c_q;
    assign done   = done_q;

endmodule

// File: tb/tb_matmul_seq_nxn.sv
// Scoreboard bench: three DUT configurations (3x3 unsigned, 3x3 signed, 2x2 DW=4).
module tb_matmul_seq_nxn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         s0, s1, s2;
    logic [71:0]  a0, b0, a1, b1;
    logic [15:0]  a2, b2;
    logic [161:0] c0, c1;
    logic [35:0]  c2;
    logic         busy0, busy1, busy2, done0, done1, done2;

    matmul_seq_nxn #(.N(3), .DW(8), .SIGNED(0)) dut0 (
        .clk(clk), .rst(rst), .start(s0), .A_flat(a0), .B_flat(b0),
        .C_flat(c0), .busy(busy0), .done(done0));
    matmul_seq_nxn #(.N(3), .DW(8), .SIGNED(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1), .A_flat(a1), .B_flat(b1),
        .C_flat(c1), .busy(busy1), .done(done1));
    matmul_seq_nxn #(.N(2), .DW(4), .SIGNED(0)) dut2 (
        .clk(clk), .rst(rst), .start(s2), .A_flat(a2), .B_flat(b2),
        .C_flat(c2), .busy(busy2), .done(done2));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [161:0] c; int t; } exp_t;
    typedef struct { int sel; logic [161:0] exp; string name; } probe_t;
    exp_t   q0[$], q1[$], q2[$];
    probe_t pq[$];
    int checks = 0;
    int errors = 0;

    int id9[9]  = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    int seq9[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int sq9[9]  = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
    int a2v[9]  = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    int b2v[9]  = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
    int c2v[9]  = '{19, 22, 43, 50, 0, 0, 0, 0, 0};

    function automatic logic [161:0] pack(input int v[9], input int w, input int n);
        logic [161:0] r = '0;
        for (int e = 0; e < n * n; e++)
            for (int b = 0; b < w; b++) r[e*w+b] = v[e][b];
        return r;
    endfunction

    function automatic logic [161:0] fill(input int val, input int w, input int n);
        int v[9];
        for (int e = 0; e < 9; e++) v[e] = val;
        return pack(v, w, n);
    endfunction

    function automatic logic [161:0] val(input int sel);
        case (sel)
            0: return c0;
            1: return 162'(busy0);
            2: return 162'(done0);
            3: return c1;
            4: return 162'(busy1);
            5: return 162'(done1);
            6: return 162'(c2);
            7: return 162'(busy2);
            8: return 162'(done2);
            default: return 162'(q0.size() + q1.size() + q2.size());
        endcase
    endfunction

    task automatic cmp(input string name, input logic [161:0] act, input logic [161:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic probe(input int sel, input logic [161:0] exp, input string name);
        probe_t p;
        p.sel = sel; p.exp = exp; p.name = name;
        pq.push_back(p);
    endtask

    task automatic push(input int id, input logic [161:0] c, input int t);
        exp_t e;
        e.c = c; e.t = t;
        if (id == 0) q0.push_back(e);
        else if (id == 1) q1.push_back(e);
        else q2.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: sample 2 time units after the falling edge, well clear of either clock edge
    initial begin
        exp_t e;
        probe_t p;
        forever begin
            @(negedge clk);
            #2;
            if (done0) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done0 actual=1 required=0");
                end else begin
                    e = q0.pop_front();
                    cmp("c0_result", c0, e.c);
                    cmp("c0_done_cycle", 162'(cyc), 162'(e.t));
                end
            end
            if (done1) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done1 actual=1 required=0");
                end else begin
                    e = q1.pop_front();
                    cmp("c1_result", c1, e.c);
                    cmp("c1_done_cycle", 162'(cyc), 162'(e.t));
                end
            end
            if (done2) begin
                if (q2.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done2 actual=1 required=0");
                end else begin
                    e = q2.pop_front();
                    cmp("c2_result", 162'(c2), e.c);
                    cmp("c2_done_cycle", 162'(cyc), 162'(e.t));
                end
            end
            while (pq.size() != 0) begin
                p = pq.pop_front();
                cmp(p.name, val(p.sel), p.exp);
            end
        end
    end

    // Stimulus
    initial begin
        int t;
        rst = 1'b1;
        s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        repeat (3) @(negedge clk);
        probe(0, '0, "reset_c0");
        probe(1, '0, "reset_busy0");
        probe(2, '0, "reset_done0");
        probe(5, '0, "reset_done1");
        probe(6, '0, "reset_c2");
        probe(7, '0, "reset_busy2");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Identity x {1..9}, signed -128 x -128, and the 2x2 case, all started together
        t  = cyc;
        a0 = 72'(pack(id9, 8, 3));  b0 = 72'(pack(seq9, 8, 3)); s0 = 1'b1;
        push(0, pack(seq9, 18, 3), t + 28);
        a1 = 72'(fill(-128, 8, 3)); b1 = 72'(fill(-128, 8, 3)); s1 = 1'b1;
        push(1, fill(49152, 18, 3), t + 28);
        a2 = 16'(pack(a2v, 4, 2));  b2 = 16'(pack(b2v, 4, 2)); s2 = 1'b1;
        push(2, pack(c2v, 9, 2), t + 9);
        @(negedge clk);
        s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
        // Inputs may change freely once latched
        a0 = 72'(fill(255, 8, 3)); b0 = 72'(fill(255, 8, 3));
        a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        probe(1, 162'(1), "busy0_after_start");
        probe(4, 162'(1), "busy1_after_start");
        probe(7, 162'(1), "busy2_after_start");

        // start while busy must be ignored
        repeat (4) @(negedge clk);
        s0 = 1'b1;
        @(negedge clk);
        s0 = 1'b0;
        probe(1, 162'(1), "busy0_ignored_start");
        wait_until(t + 12);
        probe(8, '0, "done2_one_cycle");
        probe(7, '0, "busy2_after_done");

        // Back-to-back: start presented during the done cycle
        wait_until(t + 28);
        t  = cyc;
        a0 = 72'(fill(255, 8, 3)); b0 = 72'(fill(255, 8, 3)); s0 = 1'b1;
        push(0, fill(195075, 18, 3), t + 28);
        a1 = 72'(fill(-1, 8, 3));  b1 = 72'(fill(5, 8, 3));   s1 = 1'b1;
        push(1, fill(-15, 18, 3), t + 28);
        @(negedge clk);
        s0 = 1'b0; s1 = 1'b0;
        probe(2, '0, "done0_single_pulse");
        probe(1, 162'(1), "busy0_back_to_back");
        probe(5, '0, "done1_single_pulse");
        wait_until(t + 29);
        probe(2, '0, "done0_after_second");
        probe(1, '0, "busy0_idle");
        probe(0, fill(195075, 18, 3), "c0_held");

        // Abandon a multiply with an asynchronous reset ten edges into COMPUTE
        @(negedge clk);
        t  = cyc;
        a0 = 72'(pack(seq9, 8, 3)); b0 = 72'(pack(id9, 8, 3)); s0 = 1'b1;
        @(negedge clk);
        s0 = 1'b0;
        wait_until(t + 11);
        rst = 1'b1;
        probe(0, '0, "midreset_c0");
        probe(1, '0, "midreset_busy0");
        probe(2, '0, "midreset_done0");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // A fresh multiply after reset: {1..9} squared
        t  = cyc;
        a0 = 72'(pack(seq9, 8, 3)); b0 = 72'(pack(seq9, 8, 3)); s0 = 1'b1;
        push(0, pack(sq9, 18, 3), t + 28);
        @(negedge clk);
        s0 = 1'b0;

        // Drain with a bounded wait; anything left over is reported as a failure
        t = cyc;
        while ((q0.size() + q1.size() + q2.size()) != 0 && cyc < t + 200) @(negedge clk);
        @(negedge clk);
        probe(9, '0, "pending_results");
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
